// File: rtl/pwm_capture_pkg.sv
// Shared encodings for the PWM capture unit: measurement modes and per-channel states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_capture_pkg;

   localparam logic [1:0] MODE_HIGH   = 2'd0;
   localparam logic [1:0] MODE_LOW    = 2'd1;
   localparam logic [1:0] MODE_PERIOD = 2'd2;
   localparam logic [1:0] MODE_RSVD   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_COUNT = 2'd2
   } ch_state_t;

   // The reserved encoding behaves as high-time measurement.
   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      return (m == MODE_RSVD) ? MODE_HIGH : m;
   endfunction

endpackage

// File: rtl/pwm_capture_ch.sv
// One capture channel: synchroniser, edge detect, FSM, saturating counter, result and sticky flags.
// Latency: ext_pwm edge to int_flag = SYNC_STAGES+1 cycles.
// Backpressure: none; results overwrite, flags are sticky until int_clr/clr.
module pwm_capture_ch
   import pwm_capture_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ext_pwm,
   input  logic             arm,
   input  logic             clr,
   input  logic             int_clr,
   input  logic [1:0]       mode,
   input  logic             cont,
   output logic [WIDTH-1:0] result,
   output logic             int_flag,
   output logic             ovf,
   output logic             busy
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync;
   logic                   pwm_s, pwm_q;
   logic                   rise, fall, start_edge, end_edge;
   logic [1:0]             mode_eff;
   ch_state_t              state, state_nxt;
   logic [WIDTH-1:0]       cnt, cnt_nxt, result_nxt;
   logic                   sat, sat_nxt, int_nxt, ovf_nxt;

   // Synchronise the pin and keep a delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         pwm_q <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], ext_pwm};
         pwm_q <= sync[SYNC_STAGES-1];
      end
   end

   assign pwm_s      = sync[SYNC_STAGES-1];
   assign rise       = pwm_s & ~pwm_q;
   assign fall       = ~pwm_s & pwm_q;
   assign mode_eff   = eff_mode(mode);
   assign start_edge = (mode_eff == MODE_LOW) ? fall : rise;
   assign end_edge   = (mode_eff == MODE_HIGH) ? fall : rise;

   // Channel state, counter, result and sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         sat      <= 1'b0;
         result   <= '0;
         int_flag <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         sat      <= sat_nxt;
         result   <= result_nxt;
         int_flag <= int_nxt;
         ovf      <= ovf_nxt;
      end
   end

   // Next-state: clr beats arm beats edge events; a completing capture beats int_clr.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      sat_nxt    = sat;
      result_nxt = result;
      int_nxt    = int_flag & ~int_clr;
      ovf_nxt    = ovf & ~int_clr;
      if (clr) begin
         state_nxt  = ST_IDLE;
         cnt_nxt    = '0;
         sat_nxt    = 1'b0;
         result_nxt = '0;
         int_nxt    = 1'b0;
         ovf_nxt    = 1'b0;
      end else if (arm) begin
         // Re-arming drops any partial count; the last result stays visible.
         state_nxt = ST_ARM;
         cnt_nxt   = '0;
         sat_nxt   = 1'b0;
      end else begin
         case (state)
            ST_IDLE: ;
            ST_ARM: begin
               // Only a true edge starts a count, so a level already active at arm is ignored.
               if (start_edge) begin
                  state_nxt = ST_COUNT;
                  cnt_nxt   = WIDTH'(1);
                  sat_nxt   = 1'b0;
               end
            end
            ST_COUNT: begin
               if (end_edge) begin
                  result_nxt = cnt;
                  int_nxt    = 1'b1;
                  if (sat) ovf_nxt = 1'b1;
                  sat_nxt    = 1'b0;
                  if (!cont) begin
                     state_nxt = ST_IDLE;
                     cnt_nxt   = '0;
                  end else if (mode_eff == MODE_PERIOD) begin
                     // The closing rising edge also opens the next period.
                     state_nxt = ST_COUNT;
                     cnt_nxt   = WIDTH'(1);
                  end else begin
                     state_nxt = ST_ARM;
                     cnt_nxt   = '0;
                  end
               end else if (cnt == CNT_MAX) begin
                  sat_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + WIDTH'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: rtl/pwm_capture_mc.sv
// Multi-channel PWM capture: CHANNELS capture channels, gated read mux and OR-ed interrupt.
// Latency: ext_pwm edge to int_flag/irq = SYNC_STAGES+1 cycles; data is combinational from results.
// Backpressure: none; software reads and clears flags at its own pace.
module pwm_capture_mc
   import pwm_capture_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] ext_pwm,
   input  logic [CHANNELS-1:0] ch_en,
   input  logic [1:0]          mode,
   input  logic                cont,
   input  logic                trigger,
   input  logic                clr,
   input  logic [CHANNELS-1:0] int_clr,
   input  logic [SEL_W-1:0]    rd_sel,
   input  logic                oe,
   output logic [WIDTH-1:0]    data,
   output logic [CHANNELS-1:0] int_flag,
   output logic [CHANNELS-1:0] ovf,
   output logic [CHANNELS-1:0] busy,
   output logic                irq
);

   logic [WIDTH-1:0] result [CHANNELS];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pwm_capture_ch #(
         .WIDTH       (WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .ext_pwm  (ext_pwm[i]),
         .arm      (trigger & ch_en[i]),
         .clr      (clr),
         .int_clr  (int_clr[i]),
         .mode     (mode),
         .cont     (cont),
         .result   (result[i]),
         .int_flag (int_flag[i]),
         .ovf      (ovf[i]),
         .busy     (busy[i])
      );
   end

   // Read mux: selected result when enabled; unmatched (out of range) selects read 0.
   always_comb begin
      data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (oe && (rd_sel == SEL_W'(i))) data = result[i];
      end
   end

   assign irq = |int_flag;

endmodule
